// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-code and state definitions for the Mini SRC control unit.
package cpu_pkg;

  // Instruction opcodes, ir[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // ALU operation codes; 0 is left unused so an idle bus reads as "no op"
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_SHR = 5'd5;
  localparam logic [4:0] ALU_SHL = 5'd6;
  localparam logic [4:0] ALU_ROR = 5'd7;
  localparam logic [4:0] ALU_ROL = 5'd8;
  localparam logic [4:0] ALU_NEG = 5'd9;
  localparam logic [4:0] ALU_NOT = 5'd10;
  localparam logic [4:0] ALU_INC = 5'd11;

  typedef enum logic [3:0] {
    S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
  } state_t;

  // Instruction classes that share an execute sequence
  typedef enum logic [3:0] {
    K_R, K_I, K_UN, K_LDI, K_LD, K_ST, K_BR, K_NOP, K_HALT
  } kind_t;

  function automatic kind_t op_kind(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_kind = K_R;
      OP_ADDI, OP_ANDI, OP_ORI:       op_kind = K_I;
      OP_NEG, OP_NOT:                 op_kind = K_UN;
      OP_LDI:                         op_kind = K_LDI;
      OP_LD:                          op_kind = K_LD;
      OP_ST:                          op_kind = K_ST;
      OP_BR:                          op_kind = K_BR;
      OP_HALT:                        op_kind = K_HALT;
      default:                        op_kind = K_NOP;
    endcase
  endfunction

  function automatic logic [4:0] alu_of(input logic [4:0] op);
    case (op)
      OP_SUB:          alu_of = ALU_SUB;
      OP_AND, OP_ANDI: alu_of = ALU_AND;
      OP_OR, OP_ORI:   alu_of = ALU_OR;
      OP_SHR:          alu_of = ALU_SHR;
      OP_SHL:          alu_of = ALU_SHL;
      OP_ROR:          alu_of = ALU_ROR;
      OP_ROL:          alu_of = ALU_ROL;
      OP_NEG:          alu_of = ALU_NEG;
      OP_NOT:          alu_of = ALU_NOT;
      default:         alu_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T7, strobes decoded
// from the state register and the opcode latched in T3.
module control_unit
  import cpu_pkg::*;
#(
  parameter int READ_CYCLES = 1,
  parameter int OPW         = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Pout,
  output logic        MDRout,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        Cout,
  output logic        Pen,
  output logic        IRen,
  output logic        MARen,
  output logic        MDRen,
  output logic        Yen,
  output logic        ZLOen,
  output logic        ZHIen,
  output logic        ConIn,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_control,
  output logic        run
);

  localparam logic [1:0] RD_LAST = 2'(READ_CYCLES - 1);

  state_t         state;
  logic [OPW-1:0] opc_q;
  logic [1:0]     rd_cnt;

  logic [OPW-1:0] opc_ir;
  logic [OPW-1:0] opc;
  kind_t          kind;
  kind_t          kind_ir;
  logic           unused_ir;

  assign opc_ir    = ir[31 -: OPW];
  // In T3 the opcode register is still being loaded, so decode straight from ir
  assign opc       = (state == T3) ? opc_ir : opc_q;
  assign kind      = op_kind(5'(opc));
  assign kind_ir   = op_kind(5'(opc_ir));
  assign unused_ir = ^ir[31-OPW:0];

  // State sequencing, opcode capture and the memory-read wait counter
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= S_RST;
      opc_q  <= '0;
      rd_cnt <= '0;
    end else begin
      case (state)
        S_RST: state <= T0;
        T0: begin
          state  <= T1;
          rd_cnt <= RD_LAST;
        end
        T1: begin
          if (rd_cnt != 2'd0) rd_cnt <= rd_cnt - 2'd1;
          else                state  <= T2;
        end
        T2: begin
          case (kind_ir)
            K_NOP:   state <= T0;
            K_HALT:  state <= S_HALT;
            default: state <= T3;
          endcase
        end
        T3: begin
          opc_q <= opc_ir;
          state <= T4;
        end
        T4: state <= (kind == K_UN) ? T0 : T5;
        T5: begin
          case (kind)
            K_LD: begin
              state  <= T6;
              rd_cnt <= RD_LAST;
            end
            K_ST, K_BR: state <= T6;
            default:    state <= T0;
          endcase
        end
        T6: begin
          if (kind == K_LD && rd_cnt != 2'd0) rd_cnt <= rd_cnt - 2'd1;
          else if (kind == K_LD || kind == K_ST) state <= T7;
          else state <= T0;
        end
        T7:      state <= T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  // Moore output decode; every strobe is low unless its state/class names it
  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Pout = 1'b0; MDRout = 1'b0; ZLOout = 1'b0; ZHIout = 1'b0; Cout = 1'b0;
    Pen = 1'b0; IRen = 1'b0; MARen = 1'b0; MDRen = 1'b0; Yen = 1'b0;
    ZLOen = 1'b0; ZHIen = 1'b0; ConIn = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_control = 5'd0;
    run = (state != S_RST) && (state != S_HALT);
    case (state)
      T0: begin
        Pout = 1'b1; MARen = 1'b1; ZLOen = 1'b1; alu_control = ALU_INC;
      end
      T1: begin
        // PC is written back only once even when the read is stretched
        ZLOout = 1'b1; Read = 1'b1; MDRen = 1'b1; Pen = (rd_cnt == RD_LAST);
      end
      T2: begin
        MDRout = 1'b1; IRen = 1'b1;
      end
      T3: begin
        case (kind)
          K_R, K_I: begin Grb = 1'b1; Rout = 1'b1; Yen = 1'b1; end
          K_UN: begin
            Grb = 1'b1; Rout = 1'b1; ZLOen = 1'b1; alu_control = alu_of(5'(opc));
          end
          K_LDI, K_LD, K_ST: begin Grb = 1'b1; BAout = 1'b1; Yen = 1'b1; end
          K_BR: begin Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (kind)
          K_R: begin
            Grc = 1'b1; Rout = 1'b1; ZLOen = 1'b1; ZHIen = 1'b1;
            alu_control = alu_of(5'(opc));
          end
          K_I: begin Cout = 1'b1; ZLOen = 1'b1; alu_control = alu_of(5'(opc)); end
          K_UN: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          K_LDI, K_LD, K_ST: begin Cout = 1'b1; ZLOen = 1'b1; alu_control = ALU_ADD; end
          K_BR: begin Pout = 1'b1; Yen = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (kind)
          K_R, K_I, K_LDI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          K_LD, K_ST: begin ZLOout = 1'b1; MARen = 1'b1; end
          K_BR: begin Cout = 1'b1; ZLOen = 1'b1; alu_control = ALU_ADD; end
          default: ;
        endcase
      end
      T6: begin
        case (kind)
          K_LD: begin Read = 1'b1; MDRen = 1'b1; end
          // Read stays low so the MDR input mux takes the bus value
          K_ST: begin Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1; end
          K_BR: begin ZLOout = con; Pen = con; end
          default: ;
        endcase
      end
      T7: begin
        case (kind)
          K_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          K_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes per-cycle expected
// control words, a negedge monitor pops and compares them.
module tb_control_unit;

  // Control word layout: {run, alu[4:0], Gra..Write}
  localparam logic [26:0] RN     = 27'(1) << 26;
  localparam logic [26:0] GRA    = 27'(1) << 20;
  localparam logic [26:0] GRB    = 27'(1) << 19;
  localparam logic [26:0] GRC    = 27'(1) << 18;
  localparam logic [26:0] RIN    = 27'(1) << 17;
  localparam logic [26:0] ROUT   = 27'(1) << 16;
  localparam logic [26:0] BAOUT  = 27'(1) << 15;
  localparam logic [26:0] POUT   = 27'(1) << 14;
  localparam logic [26:0] MDROUT = 27'(1) << 13;
  localparam logic [26:0] ZLOOUT = 27'(1) << 12;
  localparam logic [26:0] ZHIOUT = 27'(1) << 11;
  localparam logic [26:0] COUT   = 27'(1) << 10;
  localparam logic [26:0] PEN    = 27'(1) << 9;
  localparam logic [26:0] IREN   = 27'(1) << 8;
  localparam logic [26:0] MAREN  = 27'(1) << 7;
  localparam logic [26:0] MDREN  = 27'(1) << 6;
  localparam logic [26:0] YEN    = 27'(1) << 5;
  localparam logic [26:0] ZLOEN  = 27'(1) << 4;
  localparam logic [26:0] ZHIEN  = 27'(1) << 3;
  localparam logic [26:0] CONIN  = 27'(1) << 2;
  localparam logic [26:0] READ   = 27'(1) << 1;
  localparam logic [26:0] WRITE  = 27'(1) << 0;
  localparam logic [26:0] Z      = 27'd0;

  function automatic logic [26:0] A(input int code);
    return 27'(code) << 21;
  endfunction

  // ALU codes: ADD=1 AND=3 NEG=9 INC=11
  localparam logic [26:0] F_T0  = RN | POUT | MAREN | ZLOEN | (27'd11 << 21);
  localparam logic [26:0] F_T1P = RN | ZLOOUT | PEN | READ | MDREN;
  localparam logic [26:0] F_T1  = RN | ZLOOUT | READ | MDREN;
  localparam logic [26:0] F_T2  = RN | MDROUT | IREN;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con;
  logic [26:0] w1, w3;
  int          sel;
  string       tname;
  logic [26:0] q[$];
  int          nvec = 0;
  int          nerr = 0;
  logic        wr_seen;

  always #5 clk = ~clk;

  control_unit #(.READ_CYCLES(1), .OPW(5)) u1 (
    .clk(clk), .clr(clr), .ir(ir), .con(con),
    .Gra(w1[20]), .Grb(w1[19]), .Grc(w1[18]), .Rin(w1[17]), .Rout(w1[16]),
    .BAout(w1[15]), .Pout(w1[14]), .MDRout(w1[13]), .ZLOout(w1[12]),
    .ZHIout(w1[11]), .Cout(w1[10]), .Pen(w1[9]), .IRen(w1[8]), .MARen(w1[7]),
    .MDRen(w1[6]), .Yen(w1[5]), .ZLOen(w1[4]), .ZHIen(w1[3]), .ConIn(w1[2]),
    .Read(w1[1]), .Write(w1[0]), .alu_control(w1[25:21]), .run(w1[26])
  );

  control_unit #(.READ_CYCLES(3), .OPW(5)) u3 (
    .clk(clk), .clr(clr), .ir(ir), .con(con),
    .Gra(w3[20]), .Grb(w3[19]), .Grc(w3[18]), .Rin(w3[17]), .Rout(w3[16]),
    .BAout(w3[15]), .Pout(w3[14]), .MDRout(w3[13]), .ZLOout(w3[12]),
    .ZHIout(w3[11]), .Cout(w3[10]), .Pen(w3[9]), .IRen(w3[8]), .MARen(w3[7]),
    .MDRen(w3[6]), .Yen(w3[5]), .ZLOen(w3[4]), .ZHIen(w3[3]), .ConIn(w3[2]),
    .Read(w3[1]), .Write(w3[0]), .alu_control(w3[25:21]), .run(w3[26])
  );

  // Monitor: bus exclusivity every cycle, plus scoreboard pop/compare
  always @(negedge clk) begin
    logic [26:0] exp, act;
    nvec++;
    if ($countones(w1[16:10]) > 1 || $countones(w3[16:10]) > 1) begin
      nerr++;
      $display("FAIL bus_excl: got u1=%h u3=%h, want at most one driver", w1[16:10], w3[16:10]);
    end
    nvec++;
    if ((w1[1] && w1[0]) || (w3[1] && w3[0])) begin
      nerr++;
      $display("FAIL rd_wr_excl: got Read&Write high together");
    end
    if (w1[0]) wr_seen = 1'b1;
    if (q.size() > 0) begin
      exp = q.pop_front();
      act = (sel == 3) ? w3 : w1;
      nvec++;
      if (act !== exp) begin
        nerr++;
        $display("FAIL %s: got %h want %h", tname, act, exp);
      end
    end
  end

  task automatic push(input logic [26:0] v);
    q.push_back(v);
  endtask

  task automatic push_fetch(input int rc);
    push(F_T0);
    push(F_T1P);
    for (int i = 1; i < rc; i++) push(F_T1);
    push(F_T2);
  endtask

  // Hold clr low two cycles, release; the cycle after release is still S_RST
  task automatic begin_test(input string nm, input int s, input logic [31:0] i, input logic c);
    @(posedge clk); #1;
    tname = nm; sel = s; clr = 1'b0; ir = i; con = c;
    push(Z); push(Z);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    push(Z);
  endtask

  task automatic drain;
    int k;
    k = 0;
    while (q.size() > 0 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL %s_timeout: got %0d pending, want 0", tname, q.size());
      q.delete();
    end
  endtask

  initial begin
    clr = 1'b0; ir = 32'h0; con = 1'b0; sel = 1; tname = "init"; wr_seen = 1'b0;

    // Reset then andi r2,r3,0x53
    begin_test("andi", 1, 32'h61180053, 1'b0);
    push_fetch(1);
    push(RN | GRB | ROUT | YEN);
    push(RN | COUT | ZLOEN | A(3));
    push(RN | ZLOOUT | GRA | RIN);
    push(F_T0); push(F_T1P);
    drain();

    // add (R-type)
    begin_test("add", 1, 32'h18000000, 1'b0);
    push_fetch(1);
    push(RN | GRB | ROUT | YEN);
    push(RN | GRC | ROUT | ZLOEN | ZHIEN | A(1));
    push(RN | ZLOOUT | GRA | RIN);
    push(F_T0);
    drain();

    // neg (unary)
    begin_test("neg", 1, 32'h80000000, 1'b0);
    push_fetch(1);
    push(RN | GRB | ROUT | ZLOEN | A(9));
    push(RN | ZLOOUT | GRA | RIN);
    push(F_T0);
    drain();

    // ld with three-cycle reads
    begin_test("ld_rc3", 3, 32'h00000000, 1'b0);
    push_fetch(3);
    push(RN | GRB | BAOUT | YEN);
    push(RN | COUT | ZLOEN | A(1));
    push(RN | ZLOOUT | MAREN);
    push(RN | READ | MDREN); push(RN | READ | MDREN); push(RN | READ | MDREN);
    push(RN | MDROUT | GRA | RIN);
    push(F_T0);
    drain();

    // st
    begin_test("st", 1, 32'h10000000, 1'b0);
    push_fetch(1);
    push(RN | GRB | BAOUT | YEN);
    push(RN | COUT | ZLOEN | A(1));
    push(RN | ZLOOUT | MAREN);
    push(RN | GRA | ROUT | MDREN);
    push(RN | WRITE);
    push(F_T0);
    drain();

    // br, not taken then taken
    for (int c = 0; c < 2; c++) begin
      begin_test(c == 0 ? "br_con0" : "br_con1", 1, 32'h90000000, c[0]);
      push_fetch(1);
      push(RN | GRA | ROUT | CONIN);
      push(RN | POUT | YEN);
      push(RN | COUT | ZLOEN | A(1));
      push(c == 0 ? RN : (RN | ZLOOUT | PEN));
      push(F_T0);
      drain();
    end

    // nop and an unassigned opcode both go T2 -> T0
    begin_test("nop", 1, 32'hC8000000, 1'b0);
    push_fetch(1); push(F_T0);
    drain();
    begin_test("unassigned", 1, 32'hF8000000, 1'b0);
    push_fetch(1); push(F_T0);
    drain();

    // halt: everything low for 20 cycles; next begin_test's clr pulse restarts
    begin_test("halt", 1, 32'hD0000000, 1'b0);
    push_fetch(1);
    for (int i = 0; i < 20; i++) push(Z);
    drain();

    // restart after halt
    begin_test("post_halt", 1, 32'h61180053, 1'b0);
    push_fetch(1);
    drain();

    // st aborted by reset in T6
    begin_test("st_abort", 1, 32'h10000000, 1'b0);
    push_fetch(1);
    push(RN | GRB | BAOUT | YEN);
    push(RN | COUT | ZLOEN | A(1));
    push(RN | ZLOOUT | MAREN);
    drain();
    @(posedge clk); #1;
    nvec++;
    if (w1 !== (RN | GRA | ROUT | MDREN)) begin
      nerr++;
      $display("FAIL st_abort_t6: got %h want %h", w1, RN | GRA | ROUT | MDREN);
    end
    wr_seen = 1'b0;
    clr = 1'b0;
    #1;
    nvec++;
    if (w1 !== Z) begin
      nerr++;
      $display("FAIL st_abort_async: got %h want %h", w1, Z);
    end
    push(Z); push(Z); push(Z);
    drain();
    nvec++;
    if (wr_seen !== 1'b0) begin
      nerr++;
      $display("FAIL st_abort_write: got Write seen=%b want 0", wr_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

endmodule
